// File: rtl/fpdiv_ctrl.sv
// Sequencing controller for the single-multiplier Goldschmidt divider.
// Captures operands on accept and steps the datapath through scale/iterate/remainder.
module fpdiv_ctrl #(
  parameter int unsigned ITERS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic        rm,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] num_q,
  output logic [31:0] denom_q,
  output logic        rm_q,
  output logic        en_a,
  output logic        en_b,
  output logic        en_rem,
  output logic [1:0]  sel_mux3,
  output logic [1:0]  sel_mux4,
  output logic        busy,
  output logic        done,
  output logic [2:0]  iter
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_N,
    S_INIT_D,
    S_ITER_N,
    S_ITER_D,
    S_REM,
    S_DONE
  } state_e;

  localparam logic [3:0] ITERS4 = 4'(ITERS);

  state_e     state_q;
  state_e     state_d;
  logic [2:0] iter_d;
  logic [3:0] iter_nx;
  logic       accept;

  assign iter_nx = {1'b0, iter} + 4'd1;

  always_comb begin
    accept  = start && !flush &&
              (state_q == S_IDLE || state_q == S_DONE);
    state_d = state_q;
    iter_d  = iter;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_INIT_N;
      S_INIT_N: state_d = S_INIT_D;
      S_INIT_D: state_d = S_ITER_N;
      S_ITER_N: state_d = S_ITER_D;
      S_ITER_D: begin
        iter_d  = iter_nx[2:0];
        state_d = (iter_nx < ITERS4) ? S_ITER_N : S_REM;
      end
      S_REM:    state_d = S_DONE;
      S_DONE:   state_d = accept ? S_INIT_N : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (accept) iter_d = 3'd0;
    if (flush) begin
      state_d = S_IDLE;
      iter_d  = 3'd0;
    end
  end

  // Outputs are registered from the next state so they track state_q exactly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      iter     <= 3'd0;
      num_q    <= 32'd0;
      denom_q  <= 32'd0;
      rm_q     <= 1'b0;
      en_a     <= 1'b0;
      en_b     <= 1'b0;
      en_rem   <= 1'b0;
      sel_mux3 <= 2'd0;
      sel_mux4 <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      iter    <= iter_d;
      if (accept) begin
        num_q   <= a;
        denom_q <= b;
        rm_q    <= rm;
      end
      en_a   <= (state_d == S_INIT_N) || (state_d == S_ITER_N);
      en_b   <= (state_d == S_INIT_D) || (state_d == S_ITER_D);
      en_rem <= (state_d == S_REM);
      busy   <= (state_d != S_IDLE) && (state_d != S_DONE);
      done   <= (state_d == S_DONE);
      unique case (state_d)
        S_INIT_D: begin sel_mux3 <= 2'd0; sel_mux4 <= 2'd1; end
        S_ITER_N: begin sel_mux3 <= 2'd1; sel_mux4 <= 2'd2; end
        S_ITER_D: begin sel_mux3 <= 2'd1; sel_mux4 <= 2'd3; end
        S_REM,
        S_DONE:   begin sel_mux3 <= 2'd2; sel_mux4 <= 2'd2; end
        default:  begin sel_mux3 <= 2'd0; sel_mux4 <= 2'd0; end
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Bench for fpdiv_ctrl: ITERS=3 and ITERS=1 instances against a cycle-count model.
// Directed scenarios followed by randomized start/flush traffic.
module tb_fpdiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        rm = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;

  logic [31:0] n3, d3, n1, d1;
  logic        r3, ea3, eb3, er3, bz3, dn3;
  logic        r1, ea1, eb1, er1, bz1, dn1;
  logic [1:0]  m33, m43, m31, m41;
  logic [2:0]  it3, it1;

  fpdiv_ctrl #(.ITERS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .rm(rm), .a(a), .b(b),
    .num_q(n3), .denom_q(d3), .rm_q(r3),
    .en_a(ea3), .en_b(eb3), .en_rem(er3),
    .sel_mux3(m33), .sel_mux4(m43),
    .busy(bz3), .done(dn3), .iter(it3)
  );

  fpdiv_ctrl #(.ITERS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .rm(rm), .a(a), .b(b),
    .num_q(n1), .denom_q(d1), .rm_q(r1),
    .en_a(ea1), .en_b(eb1), .en_rem(er1),
    .sel_mux3(m31), .sel_mux4(m41),
    .busy(bz1), .done(dn1), .iter(it1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: k = cycles since accept (0 idle, 1..2N+3 busy, 2N+4 done)
  int          k[2];
  int          nn[2] = '{3, 1};
  logic [31:0] mn[2];
  logic [31:0] md[2];
  logic        mr[2];
  logic [2:0]  idle_it[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; mn[i] = 0; md[i] = 0;
      mr[i] = 0; idle_it[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int len;
      len = 2 * nn[i] + 3;
      if (flush) begin
        k[i] = 0;
        idle_it[i] = 0;
      end else if ((k[i] == 0 || k[i] == len + 1) && start) begin
        k[i] = 1;
        mn[i] = a; md[i] = b; mr[i] = rm;
      end else if (k[i] == len + 1) begin
        k[i] = 0;
        idle_it[i] = 3'(nn[i]);
      end else if (k[i] > 0) begin
        k[i]++;
      end
    end
  endtask

  // {en_a,en_b,en_rem,sel3,sel4,busy,done,iter}
  function automatic logic [11:0] exp_ctl(int kk, int n,
                                          logic [2:0] it0);
    logic ea, eb, er, bz, dn;
    logic [1:0] s3, s4;
    logic [2:0] it;
    int len;
    len = 2 * n + 3;
    ea = 0; eb = 0; er = 0; dn = 0;
    s3 = 0; s4 = 0;
    it = (kk == 0) ? it0 : 3'd0;
    bz = (kk >= 1 && kk <= len);
    if (kk == 1) begin
      ea = 1;
    end else if (kk == 2) begin
      eb = 1; s4 = 1;
    end else if (kk >= 3 && kk <= 2 * n + 2) begin
      s3 = 1;
      it = 3'((kk - 3) / 2);
      if (kk % 2 == 1) begin ea = 1; s4 = 2; end
      else begin eb = 1; s4 = 3; end
    end else if (kk == len) begin
      er = 1; s3 = 2; s4 = 2; it = 3'(n);
    end else if (kk == len + 1) begin
      dn = 1; s3 = 2; s4 = 2; it = 3'(n);
    end
    return {ea, eb, er, s3, s4, bz, dn, it};
  endfunction

  task automatic compare();
    check("i3.ctl", {ea3, eb3, er3, m33, m43, bz3, dn3, it3},
          exp_ctl(k[0], nn[0], idle_it[0]));
    check("i3.ops", {n3, d3, r3}, {mn[0], md[0], mr[0]});
    check("i1.ctl", {ea1, eb1, er1, m31, m41, bz1, dn1, it1},
          exp_ctl(k[1], nn[1], idle_it[1]));
    check("i1.ops", {n1, d1, r1}, {mn[1], md[1], mr[1]});
  endtask

  task automatic cyc(input logic st, input logic fl,
                     input logic [31:0] av, input logic [31:0] bv,
                     input logic rv);
    start = st; flush = fl; a = av; b = bv; rm = rv;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, a, b, rm);
  endtask

  int lat;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare();
    #2 reset = 1'b1;
    idle(5);

    // single divide, then measure done latency on the ITERS=3 unit
    cyc(1, 0, 32'h3FC00000, 32'h3F800000, 1'b1);
    lat = 1;
    while (!dn3 && lat < 20) begin
      cyc(0, 0, a, b, rm);
      lat++;
    end
    check("lat3", 96'(lat), 96'd10);
    idle(2);

    // back-to-back with operand change at the first DONE
    cyc(1, 0, 32'h3FC00000, 32'h3F800000, 1'b1);
    for (int i = 0; i < 24; i++) begin
      if (k[0] == 10) cyc(1, 0, 32'h40400000, b, rm);
      else cyc(1, 0, a, b, rm);
    end
    check("b2b.num", 96'(n3), 96'h40400000);
    idle(12);

    // start while busy is ignored
    cyc(1, 0, 32'h3F000000, 32'h40000000, 1'b0);
    idle(2);
    cyc(1, 0, 32'h00000000, b, rm);
    idle(10);

    // flush mid-iteration
    cyc(1, 0, 32'h41200000, 32'h40A00000, 1'b1);
    idle(3);
    cyc(0, 1, a, b, rm);
    idle(12);

    // async reset mid-operation
    cyc(1, 0, 32'h42000000, 32'h41000000, 1'b1);
    idle(4);
    #2 reset = 1'b0;
    #1 model_reset();
    compare();
    #1 reset = 1'b1;
    cyc(1, 0, 32'h3F800000, 32'h3F800000, 1'b0);
    idle(12);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 4),
          $urandom, $urandom, 1'($urandom));
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
